// File: rtl/decode_stage.sv
// Decode stage: combinational RV32/RV64 instruction decode feeding a small
// in-order output FIFO. in_ready depends only on registered state.
module decode_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_op,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_type,
    output logic            out_illegal
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    localparam logic [2:0] TypeIll = 3'd0;
    localparam logic [2:0] TypeU   = 3'd1;
    localparam logic [2:0] TypeJ   = 3'd2;
    localparam logic [2:0] TypeB   = 3'd3;
    localparam logic [2:0] TypeI   = 3'd4;
    localparam logic [2:0] TypeS   = 3'd5;
    localparam logic [2:0] TypeR   = 3'd6;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      op;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        logic [2:0]      typ;
        logic            illegal;
    } entry_t;

    entry_t          dec;
    entry_t          head;
    entry_t          mem_q [DEPTH];
    logic [31:0]     imm32;
    logic [6:0]      opc;
    logic [2:0]      typ;

    logic            ready_en_q, ready_en_d;
    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic            push, pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign opc = in_instr[6:0];

    // Classify the opcode into an instruction format.
    always_comb begin
        typ = TypeIll;
        if (in_instr[1:0] == 2'b11) begin
            case (opc)
                7'b0110111, 7'b0010111: typ = TypeU;
                7'b1101111:             typ = TypeJ;
                7'b1100011:             typ = TypeB;
                7'b1100111, 7'b0000011, 7'b0010011,
                7'b0001111, 7'b1110011: typ = TypeI;
                7'b0100011:             typ = TypeS;
                7'b0110011:             typ = TypeR;
                7'b0011011:             typ = (XLEN == 64) ? TypeI : TypeIll;
                7'b0111011:             typ = (XLEN == 64) ? TypeR : TypeIll;
                default:                typ = TypeIll;
            endcase
        end
    end

    // Extract the fields used by the format; unused fields stay zero.
    always_comb begin
        dec     = '0;
        imm32   = '0;
        dec.pc  = in_pc;
        dec.op  = opc;
        dec.typ = typ;
        case (typ)
            TypeU: begin
                dec.rd = in_instr[11:7];
                imm32  = {in_instr[31:12], 12'b0};
            end
            TypeJ: begin
                dec.rd = in_instr[11:7];
                imm32  = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                          in_instr[30:21], 1'b0};
            end
            TypeB: begin
                dec.rs1    = in_instr[19:15];
                dec.rs2    = in_instr[24:20];
                dec.funct3 = in_instr[14:12];
                imm32      = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                              in_instr[11:8], 1'b0};
            end
            TypeI: begin
                dec.rd     = in_instr[11:7];
                dec.rs1    = in_instr[19:15];
                dec.funct3 = in_instr[14:12];
                imm32      = {{20{in_instr[31]}}, in_instr[31:20]};
                // Shift-immediates keep funct7 to distinguish logical/arithmetic.
                if ((opc == 7'b0010011 || opc == 7'b0011011) &&
                    in_instr[13:12] == 2'b01) begin
                    dec.funct7 = in_instr[31:25];
                end
            end
            TypeS: begin
                dec.rs1    = in_instr[19:15];
                dec.rs2    = in_instr[24:20];
                dec.funct3 = in_instr[14:12];
                imm32      = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            TypeR: begin
                dec.rd     = in_instr[11:7];
                dec.rs1    = in_instr[19:15];
                dec.rs2    = in_instr[24:20];
                dec.funct3 = in_instr[14:12];
                dec.funct7 = in_instr[31:25];
            end
            default: dec.illegal = 1'b1;
        endcase
        dec.imm       = {XLEN{imm32[31]}};
        dec.imm[31:0] = imm32;
    end

    assign in_ready  = ready_en_q && (count_q < CntW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    // FIFO occupancy and pointer next-state; flush overrides push and pop.
    always_comb begin
        ready_en_d = 1'b1;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (!push && pop) count_d = count_q - 1'b1;
        end
    end

    // Control state; ready_en_q holds in_ready low until the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            ready_en_q <= ready_en_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Entry storage; contents are masked by count so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= dec;
    end

    // Head entry, forced to zero while the FIFO is empty.
    always_comb begin
        head = '0;
        if (count_q != '0) head = mem_q[rd_ptr_q];
    end

    assign out_pc      = head.pc;
    assign out_op      = head.op;
    assign out_rd      = head.rd;
    assign out_rs1     = head.rs1;
    assign out_rs2     = head.rs2;
    assign out_funct3  = head.funct3;
    assign out_funct7  = head.funct7;
    assign out_imm     = head.imm;
    assign out_type    = head.typ;
    assign out_illegal = head.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage (XLEN=32, DEPTH=2).
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [6:0]  out_op;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [31:0] out_imm;
    logic [2:0]  out_type;
    logic        out_illegal;

    int n_tests = 0;
    int n_fail  = 0;

    decode_stage #(
        .XLEN (32),
        .DEPTH(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_op     (out_op),
        .out_rd     (out_rd),
        .out_rs1    (out_rs1),
        .out_rs2    (out_rs2),
        .out_funct3 (out_funct3),
        .out_funct7 (out_funct7),
        .out_imm    (out_imm),
        .out_type   (out_type),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push one instruction into an empty FIFO, check the decode, then drain it.
    task automatic run_vec(input string name, input logic [31:0] instr, input logic [31:0] pc,
                           input logic [2:0] typ, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] imm, input logic ill);
        logic [6:0] op;
        op        = instr[6:0];
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = instr;
        in_pc     = pc;
        tick();
        in_valid = 1'b0;
        check({name, ".valid"},   64'(out_valid),   64'd1);
        check({name, ".pc"},      64'(out_pc),      64'(pc));
        check({name, ".op"},      64'(out_op),      64'(op));
        check({name, ".type"},    64'(out_type),    64'(typ));
        check({name, ".rd"},      64'(out_rd),      64'(rd));
        check({name, ".rs1"},     64'(out_rs1),     64'(rs1));
        check({name, ".rs2"},     64'(out_rs2),     64'(rs2));
        check({name, ".funct3"},  64'(out_funct3),  64'(f3));
        check({name, ".funct7"},  64'(out_funct7),  64'(f7));
        check({name, ".imm"},     64'(out_imm),     64'(imm));
        check({name, ".illegal"}, 64'(out_illegal), 64'(ill));
        tick();
        check({name, ".hold_imm"}, 64'(out_imm), 64'(imm));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, ".drained"},  64'(out_valid), 64'd0);
        check({name, ".zero_pc"},  64'(out_pc),    64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        out_ready = 1'b0;

        #2;
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.in_ready",  64'(in_ready),  64'd0);
        check("rst.out_imm",   64'(out_imm),   64'd0);
        #5 rst_n = 1'b1;
        #1;
        check("rel.in_ready_before_edge", 64'(in_ready), 64'd0);
        tick();
        check("rel.in_ready_after_edge", 64'(in_ready), 64'd1);

        //       name     instr         pc          type  rd  rs1 rs2 f3 f7     imm           ill
        run_vec("lui",   32'h12345537, 32'h100, 3'd1, 10, 0, 0, 0, 7'h00, 32'h12345000, 1'b0);
        run_vec("sw",    32'hFE842E23, 32'h104, 3'd5, 0,  8, 8, 2, 7'h00, 32'hFFFFFFFC, 1'b0);
        run_vec("zero",  32'h00000000, 32'h108, 3'd0, 0,  0, 0, 0, 7'h00, 32'h0,        1'b1);
        run_vec("addi",  32'hFFF00093, 32'h10C, 3'd4, 1,  0, 0, 0, 7'h00, 32'hFFFFFFFF, 1'b0);
        run_vec("srai",  32'h40335293, 32'h110, 3'd4, 5,  6, 0, 5, 7'h20, 32'h00000403, 1'b0);
        run_vec("sub",   32'h402081B3, 32'h114, 3'd6, 3,  1, 2, 0, 7'h20, 32'h0,        1'b0);
        run_vec("beq",   32'hFE208CE3, 32'h118, 3'd3, 0,  1, 2, 0, 7'h00, 32'hFFFFFFF8, 1'b0);
        run_vec("jal",   32'h008000EF, 32'h11C, 3'd2, 1,  0, 0, 0, 7'h00, 32'h00000008, 1'b0);
        run_vec("lowbit",32'h00000012, 32'h120, 3'd0, 0,  0, 0, 0, 7'h00, 32'h0,        1'b1);
        run_vec("opw32", 32'h0000001B, 32'h124, 3'd0, 0,  0, 0, 0, 7'h00, 32'h0,        1'b1);
        run_vec("ones",  32'hFFFFFFFF, 32'h128, 3'd0, 0,  0, 0, 0, 7'h00, 32'h0,        1'b1);

        // Back-pressure: three back-to-back pushes into a two-entry FIFO.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00000013;
        in_pc     = 32'h200;
        tick();
        check("bp.in_ready_after1", 64'(in_ready), 64'd1);
        in_pc = 32'h204;
        tick();
        check("bp.in_ready_full", 64'(in_ready), 64'd0);
        in_pc = 32'h208;
        tick();
        check("bp.in_ready_third", 64'(in_ready), 64'd0);
        check("bp.head_a", 64'(out_pc), 64'h200);
        // Pop on full: the pending third instruction must not be taken.
        out_ready = 1'b1;
        tick();
        check("bp.in_ready_after_pop", 64'(in_ready), 64'd1);
        check("bp.head_b", 64'(out_pc), 64'h204);
        // Simultaneous push and pop keeps one entry.
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("bp.valid_pushpop", 64'(out_valid), 64'd1);
        check("bp.in_ready_pushpop", 64'(in_ready), 64'd1);
        check("bp.head_c", 64'(out_pc), 64'h208);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp.empty", 64'(out_valid), 64'd0);

        // Flush with a full FIFO and a pending push.
        in_valid = 1'b1;
        in_pc    = 32'h300;
        tick();
        in_pc = 32'h304;
        tick();
        check("fl.full", 64'(in_ready), 64'd0);
        flush = 1'b1;
        in_pc = 32'h308;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl.out_valid", 64'(out_valid), 64'd0);
        check("fl.in_ready",  64'(in_ready),  64'd1);
        check("fl.out_pc",    64'(out_pc),    64'd0);
        tick();
        check("fl.never_appears", 64'(out_valid), 64'd0);

        // Asynchronous reset between edges with two entries buffered.
        in_valid = 1'b1;
        in_pc    = 32'h380;
        tick();
        in_pc = 32'h384;
        tick();
        in_valid = 1'b0;
        check("ar.filled", 64'(out_pc), 64'h380);
        #2 rst_n = 1'b0;
        #1;
        check("ar.out_valid_now", 64'(out_valid), 64'd0);
        check("ar.in_ready_now",  64'(in_ready),  64'd0);
        check("ar.out_pc_now",    64'(out_pc),    64'd0);
        #1 rst_n = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h12345537;
        in_pc    = 32'h400;
        tick();
        check("ar.not_taken_first_edge", 64'(out_valid), 64'd0);
        check("ar.in_ready_first_edge",  64'(in_ready),  64'd1);
        tick();
        in_valid = 1'b0;
        check("ar.new_valid", 64'(out_valid), 64'd1);
        check("ar.new_pc",    64'(out_pc),    64'h400);
        check("ar.new_type",  64'(out_type),  64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
